// File: rtl/df_dl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : df_dl_pkg
// Purpose  : Shared types and helpers for the dataflow deadlock detector.
//            - dl_state_e        : detector state encoding
//            - lowest_set_index  : priority encoder (lowest index wins)
//            - all_blocked       : true when at least one process is active and
//                                  every active process is blocked
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package df_dl_pkg;

  // Helpers operate on a fixed-width vector; callers zero-extend narrower
  // process vectors to this width. Builds with more processes must raise it.
  localparam int c_max_proc = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WATCH    = 3'd1,
    SUSPECT  = 3'd2,
    DEADLOCK = 3'd3,
    FINISHED = 3'd4
  } dl_state_e;

  // Returns the lowest set bit position, or 0 for an all-zero mask.
  function automatic int unsigned lowest_set_index(input logic [c_max_proc-1:0] mask);
    lowest_set_index = 0;
    for (int i = c_max_proc - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set_index = i;
    end
  endfunction

  // Upper (unused) bits of active are zero, so the inverted upper bits of
  // blocked never contribute.
  function automatic logic all_blocked(input logic [c_max_proc-1:0] active,
                                       input logic [c_max_proc-1:0] blocked);
    all_blocked = (active != '0) && ((active & ~blocked) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/df_deadlock_detector.sv
`default_nettype none
// ============================================================================
// Module   : df_deadlock_detector
// Purpose  : Watchdog for one HLS dataflow region. Declares a sticky deadlock
//            when every active process has been blocked on a channel, with an
//            unchanged blocked pattern and no handshake progress, for
//            THRESHOLD consecutive cycles.
// Ports    :
//   clock, reset        - clock, synchronous active-high reset
//   enable              - detection enable (0 forces IDLE)
//   region_idle         - region has no work in flight (forces IDLE)
//   finish              - end of run; moves to terminal FINISHED state
//   proc_active         - per-process started-and-not-done
//   proc_cin_stall      - per-process waiting on empty input channel
//   proc_cout_stall     - per-process waiting on full output channel
//   proc_progress       - per-process channel handshake this cycle
//   find_df_deadlock    - sticky deadlock flag (registered)
//   deadlock_mask       - blocked-process snapshot at detection
//   deadlock_first      - lowest index set in deadlock_mask
//   suspect_events      - saturating count of SUSPECT entries
//   busy                - registered decode: state is WATCH or SUSPECT
// Revision : 1.0 - initial release
// ============================================================================
module df_deadlock_detector
  import df_dl_pkg::*;
#(
  parameter int N_PROC    = 4,
  parameter int THRESHOLD = 1024,
  parameter int EVT_W     = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      region_idle,
  input  logic                      finish,
  input  logic [N_PROC-1:0]         proc_active,
  input  logic [N_PROC-1:0]         proc_cin_stall,
  input  logic [N_PROC-1:0]         proc_cout_stall,
  input  logic [N_PROC-1:0]         proc_progress,
  output logic                      find_df_deadlock,
  output logic [N_PROC-1:0]         deadlock_mask,
  output logic [$clog2(N_PROC)-1:0] deadlock_first,
  output logic [EVT_W-1:0]          suspect_events,
  output logic                      busy
);

  localparam int c_cnt_w   = $clog2(THRESHOLD + 1);
  localparam int c_first_w = $clog2(N_PROC);

  dl_state_e           r_state;
  dl_state_e           w_state_next;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_cnt_w-1:0]  w_count_next;
  logic [N_PROC-1:0]   r_snapshot;
  logic [N_PROC-1:0]   w_snapshot_next;
  logic                w_event_inc;
  logic [N_PROC-1:0]   w_blocked;
  logic                w_all_blocked;
  logic                w_same_pattern;
  logic                w_detect;

  // Progress overrides a stall: a process that handshaked this cycle is not
  // blocked even if its stall indication is also high.
  assign w_blocked      = proc_active & (proc_cin_stall | proc_cout_stall) & ~proc_progress;
  assign w_all_blocked  = all_blocked(c_max_proc'(proc_active), c_max_proc'(w_blocked));
  assign w_same_pattern = (w_blocked == r_snapshot);

  // Next-state / next-count logic.
  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_snapshot_next = r_snapshot;
    w_event_inc     = 1'b0;

    unique case (r_state)
      IDLE, WATCH, SUSPECT: begin
        if (finish) begin
          // finish beats a detecting sample in the same cycle
          w_state_next    = FINISHED;
          w_count_next    = '0;
          w_snapshot_next = '0;
        end else if (!enable || region_idle) begin
          w_state_next    = IDLE;
          w_count_next    = '0;
          w_snapshot_next = '0;
        end else if (r_state == IDLE) begin
          w_state_next = WATCH;
          w_count_next = '0;
        end else if (r_state == WATCH) begin
          w_count_next = '0;
          if (w_all_blocked) begin
            w_state_next    = SUSPECT;
            w_count_next    = c_cnt_w'(1);
            w_snapshot_next = w_blocked;
            w_event_inc     = 1'b1;
          end
        end else begin
          // SUSPECT: count holds the number of samples already in the streak
          if (w_all_blocked && w_same_pattern) begin
            w_count_next = r_count + c_cnt_w'(1);
            if (r_count == c_cnt_w'(THRESHOLD - 1)) begin
              w_state_next = DEADLOCK;
            end
          end else begin
            w_state_next = WATCH;
            w_count_next = '0;
          end
        end
      end
      DEADLOCK: begin
        w_state_next = DEADLOCK;
      end
      FINISHED: begin
        w_state_next = FINISHED;
        w_count_next = '0;
      end
      default: begin
        w_state_next    = IDLE;
        w_count_next    = '0;
        w_snapshot_next = '0;
      end
    endcase
  end

  assign w_detect = (w_state_next == DEADLOCK) && (r_state != DEADLOCK);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= IDLE;
      r_count          <= '0;
      r_snapshot       <= '0;
      find_df_deadlock <= 1'b0;
      deadlock_mask    <= '0;
      deadlock_first   <= '0;
      suspect_events   <= '0;
      busy             <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_snapshot <= w_snapshot_next;
      busy       <= (w_state_next == WATCH) || (w_state_next == SUSPECT);

      if (w_event_inc && (suspect_events != '1)) begin
        suspect_events <= suspect_events + EVT_W'(1);
      end

      // Detection outputs are only ever written on entry to DEADLOCK, so they
      // remain 0 in every other state, including FINISHED.
      if (w_detect) begin
        find_df_deadlock <= 1'b1;
        deadlock_mask    <= r_snapshot;
        deadlock_first   <= c_first_w'(lowest_set_index(c_max_proc'(r_snapshot)));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_df_deadlock_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_df_deadlock_detector
// Purpose  : Directed self-checking bench for df_deadlock_detector with
//            N_PROC=4, THRESHOLD=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_df_deadlock_detector;

  localparam int N_PROC    = 4;
  localparam int THRESHOLD = 8;
  localparam int EVT_W     = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              region_idle;
  logic              finish;
  logic [N_PROC-1:0] proc_active;
  logic [N_PROC-1:0] proc_cin_stall;
  logic [N_PROC-1:0] proc_cout_stall;
  logic [N_PROC-1:0] proc_progress;
  logic              find_df_deadlock;
  logic [N_PROC-1:0] deadlock_mask;
  logic [1:0]        deadlock_first;
  logic [EVT_W-1:0]  suspect_events;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int flag_seen;

  df_deadlock_detector #(
    .N_PROC   (N_PROC),
    .THRESHOLD(THRESHOLD),
    .EVT_W    (EVT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .region_idle     (region_idle),
    .finish          (finish),
    .proc_active     (proc_active),
    .proc_cin_stall  (proc_cin_stall),
    .proc_cout_stall (proc_cout_stall),
    .proc_progress   (proc_progress),
    .find_df_deadlock(find_df_deadlock),
    .deadlock_mask   (deadlock_mask),
    .deadlock_first  (deadlock_first),
    .suspect_events  (suspect_events),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Advance one clock edge; outputs are observed 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tick n times and record whether the flag was ever seen high.
  task automatic ticks_watch_flag(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (find_df_deadlock !== 1'b0) flag_seen = 1;
    end
  endtask

  task automatic set_blocked_all();
    proc_active     = 4'b1111;
    proc_cin_stall  = 4'b1110;
    proc_cout_stall = 4'b0001;
    proc_progress   = 4'b0000;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b1;
    region_idle = 1'b1;
    finish      = 1'b0;
    proc_active = '0; proc_cin_stall = '0; proc_cout_stall = '0; proc_progress = '0;
    ticks(2);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    // ---------------- 1. reset with random inputs ----------------
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable          = 1'($urandom);
      region_idle     = 1'($urandom);
      finish          = 1'($urandom);
      proc_active     = 4'($urandom);
      proc_cin_stall  = 4'($urandom);
      proc_cout_stall = 4'($urandom);
      proc_progress   = 4'($urandom);
      tick();
    end
    chk("rst_flag",   {31'd0, find_df_deadlock}, 32'd0);
    chk("rst_mask",   {28'd0, deadlock_mask},    32'd0);
    chk("rst_first",  {30'd0, deadlock_first},   32'd0);
    chk("rst_events", {16'd0, suspect_events},   32'd0);
    chk("rst_busy",   {31'd0, busy},             32'd0);
    reset = 1'b0; enable = 1'b1; region_idle = 1'b1; finish = 1'b0;
    set_blocked_all();
    ticks(4);
    chk("idle_hold_busy", {31'd0, busy}, 32'd0);

    // ---------------- 2. full deadlock ----------------
    do_reset();
    region_idle = 1'b0;
    set_blocked_all();
    tick();                         // IDLE -> WATCH
    chk("t2_watch_busy", {31'd0, busy}, 32'd1);
    ticks(7);                       // samples 1..7
    chk("t2_no_flag_at7", {31'd0, find_df_deadlock}, 32'd0);
    tick();                         // 8th sample
    chk("t2_flag",   {31'd0, find_df_deadlock}, 32'd1);
    chk("t2_mask",   {28'd0, deadlock_mask},    32'hF);
    chk("t2_first",  {30'd0, deadlock_first},   32'd0);
    chk("t2_events", {16'd0, suspect_events},   32'd1);
    chk("t2_busy",   {31'd0, busy},             32'd0);
    // terminal: ignores finish / enable
    finish = 1'b1; enable = 1'b0;
    ticks(3);
    chk("t2_sticky", {31'd0, find_df_deadlock}, 32'd1);
    // reset mid-deadlock clears everything on the next cycle
    reset = 1'b1;
    tick();
    chk("t2_rst_flag",   {31'd0, find_df_deadlock}, 32'd0);
    chk("t2_rst_mask",   {28'd0, deadlock_mask},    32'd0);
    chk("t2_rst_events", {16'd0, suspect_events},   32'd0);

    // ---------------- 3. transient stall ----------------
    do_reset();
    region_idle = 1'b0;
    set_blocked_all();
    tick();                         // WATCH
    ticks(7);                       // 7 samples
    proc_progress = 4'b0100;
    tick();                         // streak broken -> WATCH
    chk("t3_no_flag", {31'd0, find_df_deadlock}, 32'd0);
    chk("t3_busy",    {31'd0, busy},             32'd1);
    proc_progress = 4'b0000;
    ticks(7);
    chk("t3_no_flag_at7", {31'd0, find_df_deadlock}, 32'd0);
    tick();
    chk("t3_flag",   {31'd0, find_df_deadlock}, 32'd1);
    chk("t3_events", {16'd0, suspect_events},   32'd2);

    // ---------------- 4. pattern change ----------------
    do_reset();
    region_idle = 1'b0;
    set_blocked_all();
    tick();                         // WATCH
    ticks(5);                       // 5 samples with 1111
    proc_active = 4'b1110;          // blocked becomes 1110 (differs from snapshot)
    tick();                         // -> WATCH
    ticks(7);
    chk("t4_no_flag_at7", {31'd0, find_df_deadlock}, 32'd0);
    tick();
    chk("t4_flag",   {31'd0, find_df_deadlock}, 32'd1);
    chk("t4_mask",   {28'd0, deadlock_mask},    32'hE);
    chk("t4_first",  {30'd0, deadlock_first},   32'd1);
    chk("t4_events", {16'd0, suspect_events},   32'd2);

    // ---------------- 5. finish on the 8th sample ----------------
    do_reset();
    region_idle = 1'b0;
    set_blocked_all();
    tick();                         // WATCH
    ticks(7);
    finish = 1'b1;
    tick();                         // 8th sample + finish -> FINISHED
    finish = 1'b0;
    flag_seen = 0;
    if (find_df_deadlock !== 1'b0) flag_seen = 1;
    ticks_watch_flag(100);
    chk("t5_never_flag", flag_seen, 0);
    chk("t5_busy",       {31'd0, busy},           32'd0);
    chk("t5_mask",       {28'd0, deadlock_mask},  32'd0);
    chk("t5_events",     {16'd0, suspect_events}, 32'd1);

    // ---------------- 6a. region_idle at count 6 ----------------
    do_reset();
    region_idle = 1'b0;
    set_blocked_all();
    tick();                         // WATCH
    ticks(6);
    region_idle = 1'b1;
    tick();                         // -> IDLE
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    region_idle = 1'b0;
    tick();                         // IDLE -> WATCH
    ticks(7);
    chk("t6_no_flag_at7", {31'd0, find_df_deadlock}, 32'd0);
    tick();
    chk("t6_flag",   {31'd0, find_df_deadlock}, 32'd1);
    chk("t6_events", {16'd0, suspect_events},   32'd2);

    // ---------------- 6b. enable=0 while blocked ----------------
    do_reset();
    region_idle = 1'b0;
    enable      = 1'b0;
    set_blocked_all();
    flag_seen = 0;
    ticks_watch_flag(30);
    chk("t6b_never_flag", flag_seen, 0);
    chk("t6b_busy",       {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
